nes_mem_sched: RTL and testbench

Sequencer that shares the single external cartridge memory port between the three agents that address it: the PPU CHR path (mapper `chr_aout`), the CPU PRG path (mapper `prg_aout`, ROM or PRG-RAM) and the boot-time ROM loader. It sits between the mapper outputs and the SDRAM/BRAM controller. It latches one pending request per agent, grants by priority with anti-starvation, and runs a req/ack handshake to memory. Read data and completion pulses go back to each agent.

---
 rtl/nes_mem_pkg.sv | 24 ++
 rtl/nes_mem_sched_if.sv | 23 ++
 rtl/nes_mem_slot.sv | 70 +++++++
 rtl/nes_mem_sched.sv | 202 ++++++++++++++++++++
 tb/tb_nes_mem_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nes_mem_pkg.sv
// Shared types and constants for the cartridge memory scheduler.
package nes_mem_pkg;

    // Physical address width, matching the mapper prg_aout/chr_aout buses.
    localparam int ADDR_W_DEFAULT = 22;

    // Number of agents sharing the memory port.
    localparam int N_AG = 3;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Agent index; the numeric values index the per-agent arrays.
    typedef enum logic [1:0] {
        AG_PPU = 2'd0,
        AG_CPU = 2'd1,
        AG_LDR = 2'd2
    } agent_t;

endpackage

// File: rtl/nes_mem_sched_if.sv
// Request/acknowledge bus between the scheduler and the SDRAM/BRAM controller.
interface nes_mem_sched_if #(
    parameter int ADDR_W = nes_mem_pkg::ADDR_W_DEFAULT
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    // Scheduler side: issues requests, receives acknowledge and read data.
    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Memory controller side.
    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/nes_mem_slot.sv
// One-deep pending request slot for a single agent, with busy and sticky
// overflow tracking. A request arriving while busy is dropped.
module nes_mem_slot
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [7:0]        i_din,
    input  logic              i_clear,      // slot granted this cycle
    input  logic              i_svc_next,   // agent will be in WAIT next cycle
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic [7:0]        o_din,
    output logic              o_busy,
    output logic              o_ovf
);

    logic              r_valid;
    logic              r_busy;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [7:0]        r_din;

    logic w_accept;
    logic w_valid_next;

    assign w_accept     = i_req & ~r_busy;
    assign w_valid_next = w_accept | (r_valid & ~i_clear);

    // Control state: valid, registered busy and sticky overflow.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            r_busy  <= w_valid_next | i_svc_next;
            r_ovf   <= r_ovf | (i_req & r_busy);
        end
    end

    // Request payload, captured only when a request is accepted.
    always_ff @(posedge clk) begin
        // NOTE: payload is qualified by r_valid and never observed while
        // invalid, so it carries no reset; keeps it plain enable flops.
        if (w_accept) begin
            r_addr <= i_addr;
            r_we   <= i_we;
            r_din  <= i_din;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_we    = r_we;
    assign o_din   = r_din;
    assign o_busy  = r_busy;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/nes_mem_sched.sv
// Shares the single cartridge memory port between PPU CHR, CPU PRG and the
// boot ROM loader. One pending slot per agent, priority PPU > CPU > LDR with
// CPU winning right after a PPU grant, and a req/ack handshake to memory.
module nes_mem_sched
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ldr_mode,

    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic              ppu_we,
    input  logic [7:0]        ppu_din,
    output logic              ppu_busy,
    output logic              ppu_done,
    output logic [7:0]        ppu_dout,
    output logic              ppu_ovf,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_din,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ovf,

    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic              ldr_we,
    input  logic [7:0]        ldr_din,
    output logic              ldr_busy,
    output logic              ldr_done,
    output logic [7:0]        ldr_dout,
    output logic              ldr_ovf,

    nes_mem_sched_if.master   mem
);

    // Per-agent request inputs gathered into index-addressable arrays.
    logic [N_AG-1:0]   w_req_in;
    logic [N_AG-1:0]   w_we_in;
    logic [ADDR_W-1:0] w_addr_in [N_AG];
    logic [7:0]        w_din_in  [N_AG];

    assign w_req_in = {ldr_req, cpu_req, ppu_req};
    assign w_we_in  = {ldr_we,  cpu_we,  ppu_we};
    assign w_addr_in[AG_PPU] = ppu_addr;
    assign w_addr_in[AG_CPU] = cpu_addr;
    assign w_addr_in[AG_LDR] = ldr_addr;
    assign w_din_in[AG_PPU]  = ppu_din;
    assign w_din_in[AG_CPU]  = cpu_din;
    assign w_din_in[AG_LDR]  = ldr_din;

    // Slot outputs and slot control.
    logic [N_AG-1:0]   w_valid;
    logic [N_AG-1:0]   w_slot_we;
    logic [ADDR_W-1:0] w_slot_addr [N_AG];
    logic [7:0]        w_slot_din  [N_AG];
    logic [N_AG-1:0]   w_busy;
    logic [N_AG-1:0]   w_ovf;
    logic [N_AG-1:0]   w_clear;
    logic [N_AG-1:0]   w_svc_next;

    // Scheduler registers.
    state_t            r_state;
    agent_t            r_grant;
    logic              r_last_ppu;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;
    logic [N_AG-1:0]   r_done;
    logic [7:0]        r_dout [N_AG];

    // Arbiter results.
    logic [N_AG-1:0]   w_elig;
    logic              w_grant_vld;
    agent_t            w_grant_idx;

    for (genvar g = 0; g < N_AG; g++) begin : g_slot
        nes_mem_slot #(
            .ADDR_W (ADDR_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .i_req      (w_req_in[g]),
            .i_addr     (w_addr_in[g]),
            .i_we       (w_we_in[g]),
            .i_din      (w_din_in[g]),
            .i_clear    (w_clear[g]),
            .i_svc_next (w_svc_next[g]),
            .o_valid    (w_valid[g]),
            .o_addr     (w_slot_addr[g]),
            .o_we       (w_slot_we[g]),
            .o_din      (w_slot_din[g]),
            .o_busy     (w_busy[g]),
            .o_ovf      (w_ovf[g])
        );
    end

    // During boot load only the loader may go; otherwise the loader never does.
    assign w_elig = ldr_mode ? (w_valid & 3'b100) : (w_valid & 3'b011);

    // Priority pick with the CPU-after-PPU anti-starvation exception.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would infer a latch.
        w_grant_vld = (r_state == IDLE) && (|w_elig);
        w_grant_idx = AG_LDR;
        if (r_last_ppu && w_elig[AG_CPU]) begin
            w_grant_idx = AG_CPU;
        end else if (w_elig[AG_PPU]) begin
            w_grant_idx = AG_PPU;
        end else if (w_elig[AG_CPU]) begin
            w_grant_idx = AG_CPU;
        end
    end

    // Slot clear on grant, and look-ahead of which agent sits in WAIT next
    // cycle so the slot can register its busy flag.
    always_comb begin
        w_clear    = '0;
        w_svc_next = '0;
        for (int a = 0; a < N_AG; a++) begin
            w_clear[a]    = w_grant_vld && (w_grant_idx == agent_t'(a));
            w_svc_next[a] = w_clear[a] ||
                            ((r_state == WAIT) && !mem.mem_ack &&
                             (r_grant == agent_t'(a)));
        end
    end

    // Scheduler FSM: grant in IDLE, hold mem_req in WAIT, pulse done in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= AG_PPU;
            r_last_ppu  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_done      <= '0;
            for (int a = 0; a < N_AG; a++) begin
                r_dout[a] <= '0;
            end
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_grant     <= w_grant_idx;
                        r_last_ppu  <= (w_grant_idx == AG_PPU);
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_slot_addr[w_grant_idx];
                        r_mem_we    <= w_slot_we[w_grant_idx];
                        r_mem_wdata <= w_slot_din[w_grant_idx];
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_dout[r_grant] <= mem.mem_rdata;
                        end
                        r_done[r_grant] <= 1'b1;
                        r_state         <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_wdata = r_mem_wdata;

    assign ppu_busy = w_busy[AG_PPU];
    assign cpu_busy = w_busy[AG_CPU];
    assign ldr_busy = w_busy[AG_LDR];
    assign ppu_done = r_done[AG_PPU];
    assign cpu_done = r_done[AG_CPU];
    assign ldr_done = r_done[AG_LDR];
    assign ppu_dout = r_dout[AG_PPU];
    assign cpu_dout = r_dout[AG_CPU];
    assign ldr_dout = r_dout[AG_LDR];
    assign ppu_ovf  = w_ovf[AG_PPU];
    assign cpu_ovf  = w_ovf[AG_CPU];
    assign ldr_ovf  = w_ovf[AG_LDR];

endmodule

// File: tb/tb_nes_mem_sched.sv
// Randomized bench for nes_mem_sched against a cycle-level reference model
// built from the scheduling rules, plus directed scenarios.
module tb_nes_mem_sched;
    import nes_mem_pkg::*;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          ldr_mode;
    logic          ppu_req, cpu_req, ldr_req;
    logic [AW-1:0] ppu_addr, cpu_addr, ldr_addr;
    logic          ppu_we, cpu_we, ldr_we;
    logic [7:0]    ppu_din, cpu_din, ldr_din;
    logic          ppu_busy, cpu_busy, ldr_busy;
    logic          ppu_done, cpu_done, ldr_done;
    logic [7:0]    ppu_dout, cpu_dout, ldr_dout;
    logic          ppu_ovf, cpu_ovf, ldr_ovf;

    nes_mem_sched_if #(.ADDR_W(AW)) mem_if ();

    nes_mem_sched #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ldr_mode (ldr_mode),
        .ppu_req  (ppu_req),  .ppu_addr (ppu_addr), .ppu_we (ppu_we), .ppu_din (ppu_din),
        .ppu_busy (ppu_busy), .ppu_done (ppu_done), .ppu_dout (ppu_dout), .ppu_ovf (ppu_ovf),
        .cpu_req  (cpu_req),  .cpu_addr (cpu_addr), .cpu_we (cpu_we), .cpu_din (cpu_din),
        .cpu_busy (cpu_busy), .cpu_done (cpu_done), .cpu_dout (cpu_dout), .cpu_ovf (cpu_ovf),
        .ldr_req  (ldr_req),  .ldr_addr (ldr_addr), .ldr_we (ldr_we), .ldr_din (ldr_din),
        .ldr_busy (ldr_busy), .ldr_done (ldr_done), .ldr_dout (ldr_dout), .ldr_ovf (ldr_ovf),
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    // Observed DUT outputs in index form.
    logic [2:0] d_busy, d_done, d_ovf;
    logic [7:0] d_dout [3];
    assign d_busy = {ldr_busy, cpu_busy, ppu_busy};
    assign d_done = {ldr_done, cpu_done, ppu_done};
    assign d_ovf  = {ldr_ovf, cpu_ovf, ppu_ovf};
    assign d_dout[0] = ppu_dout;
    assign d_dout[1] = cpu_dout;
    assign d_dout[2] = ldr_dout;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Stimulus for the current cycle.
    bit       st_req [3];
    bit       st_we  [3];
    int       st_addr[3];
    bit [7:0] st_din [3];
    bit       st_reset;
    bit       st_ldr;

    // Memory responder state.
    bit       mem_auto;
    int       max_wd;
    int       wd, wcnt;
    bit       force_ack;
    bit [7:0] force_rdata;
    int       n_acks;
    bit [7:0] mem_arr[int];
    bit [7:0] ref_arr[int];

    // Reference model state and expected outputs.
    bit       m_pend [3];
    int       m_paddr[3];
    bit       m_pwe  [3];
    bit [7:0] m_pdin [3];
    int       m_phase;     // 0 idle, 1 waiting on memory, 2 completing
    int       m_cur;
    bit       m_last_ppu;
    bit       e_busy[3], e_done[3], e_ovf[3];
    bit [7:0] e_dout[3];
    bit       e_req, e_we;
    int       e_addr;
    bit [7:0] e_wdata;

    bit chk_en;
    int done_q[$];

    function automatic bit [7:0] init_byte(int a);
        return 8'((a * 37) + (a >>> 8) + 8'h5A);
    endfunction

    function automatic bit [7:0] mem_rd(int a);
        return mem_arr.exists(a) ? mem_arr[a] : init_byte(a);
    endfunction

    function automatic bit [7:0] ref_rd(int a);
        return ref_arr.exists(a) ? ref_arr[a] : init_byte(a);
    endfunction

    function automatic int q_at(int i);
        return (i < done_q.size()) ? done_q[i] : -1;
    endfunction

    // Next agent by the priority rules, or -1 when none is eligible.
    function automatic int pick(bit lm);
        bit el[3];
        for (int a = 0; a < 3; a++) el[a] = m_pend[a] && (lm ? (a == 2) : (a != 2));
        if (m_last_ppu && el[1]) return 1;
        for (int a = 0; a < 3; a++) if (el[a]) return a;
        return -1;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            m_pend[a] = 0; e_busy[a] = 0; e_done[a] = 0; e_ovf[a] = 0; e_dout[a] = 0;
        end
        m_phase = 0; m_cur = 0; m_last_ppu = 0;
        e_req = 0; e_addr = 0; e_we = 0; e_wdata = 0;
    endtask

    // Advance the model by one cycle given this cycle's inputs.
    task automatic model_step(input bit ack);
        bit busy_now[3];
        int g;
        if (st_reset) begin
            model_reset();
            return;
        end
        for (int a = 0; a < 3; a++) begin
            busy_now[a] = m_pend[a] || (m_phase == 1 && m_cur == a);
            e_done[a]   = 0;
        end
        case (m_phase)
            0: begin
                g = pick(st_ldr);
                if (g >= 0) begin
                    m_cur = g; m_last_ppu = (g == 0);
                    e_addr = m_paddr[g]; e_we = m_pwe[g]; e_wdata = m_pdin[g];
                    m_pend[g] = 0; m_phase = 1;
                end
            end
            1: if (ack) begin
                if (e_we) ref_arr[e_addr] = e_wdata;
                else e_dout[m_cur] = ref_rd(e_addr);
                e_done[m_cur] = 1; m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        for (int a = 0; a < 3; a++) begin
            if (st_req[a]) begin
                if (busy_now[a]) e_ovf[a] = 1;
                else begin
                    m_pend[a] = 1; m_paddr[a] = st_addr[a]; m_pwe[a] = st_we[a]; m_pdin[a] = st_din[a];
                end
            end
        end
        for (int a = 0; a < 3; a++) e_busy[a] = m_pend[a] || (m_phase == 1 && m_cur == a);
        e_req = (m_phase == 1);
    endtask

    // One cycle: check outputs, drive memory and agent inputs, step the model.
    task automatic tick();
        bit ack;
        int ma;
        if (chk_en) begin
            for (int a = 0; a < 3; a++) begin
                check($sformatf("busy%0d", a), 32'(d_busy[a]), 32'(e_busy[a]));
                check($sformatf("done%0d", a), 32'(d_done[a]), 32'(e_done[a]));
                check($sformatf("ovf%0d", a),  32'(d_ovf[a]),  32'(e_ovf[a]));
                check($sformatf("dout%0d", a), 32'(d_dout[a]), 32'(e_dout[a]));
                if (d_done[a]) done_q.push_back(a);
            end
            check("mem_req",   32'(mem_if.mem_req),   32'(e_req));
            check("mem_addr",  32'(mem_if.mem_addr),  32'(e_addr));
            check("mem_we",    32'(mem_if.mem_we),    32'(e_we));
            check("mem_wdata", 32'(mem_if.mem_wdata), 32'(e_wdata));
        end
        ack = 0;
        mem_if.mem_rdata = 8'($urandom);
        if (mem_auto) begin
            if (mem_if.mem_req === 1'b1) begin
                if (wcnt >= wd) begin
                    ack = 1; n_acks++;
                    ma = int'(mem_if.mem_addr);
                    if (mem_if.mem_we) mem_arr[ma] = mem_if.mem_wdata;
                    else mem_if.mem_rdata = mem_rd(ma);
                    wcnt = 0; wd = $urandom_range(0, max_wd);
                end else wcnt++;
            end
        end else begin
            ack = force_ack;
            if (force_ack) mem_if.mem_rdata = force_rdata;
        end
        mem_if.mem_ack = ack;
        reset    = st_reset;
        ldr_mode = st_ldr;
        ppu_req = st_req[0]; ppu_we = st_we[0]; ppu_din = st_din[0]; ppu_addr = st_addr[0][AW-1:0];
        cpu_req = st_req[1]; cpu_we = st_we[1]; cpu_din = st_din[1]; cpu_addr = st_addr[1][AW-1:0];
        ldr_req = st_req[2]; ldr_we = st_we[2]; ldr_din = st_din[2]; ldr_addr = st_addr[2][AW-1:0];
        model_step(ack);
        @(negedge clk);
    endtask

    task automatic clr_req();
        for (int a = 0; a < 3; a++) st_req[a] = 0;
    endtask

    task automatic set_req(input int a, input int addr, input bit we, input bit [7:0] din);
        st_req[a] = 1; st_addr[a] = addr; st_we[a] = we; st_din[a] = din;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int lat, pos, acks0;
        clr_req();
        for (int a = 0; a < 3; a++) begin st_we[a] = 0; st_addr[a] = 0; st_din[a] = 0; end
        st_reset = 1; st_ldr = 0; chk_en = 0;
        mem_auto = 1; max_wd = 0; wd = 0; wcnt = 0; force_ack = 0; force_rdata = 0; n_acks = 0;
        reset = 1; ldr_mode = 0; mem_if.mem_ack = 0; mem_if.mem_rdata = 0;
        ppu_req = 0; cpu_req = 0; ldr_req = 0;
        ppu_addr = 0; cpu_addr = 0; ldr_addr = 0;
        ppu_we = 0; cpu_we = 0; ldr_we = 0; ppu_din = 0; cpu_din = 0; ldr_din = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk_en = 1;
        tick();                 // reset state checked here
        st_reset = 0;
        tick();

        // CPU read with zero-wait memory: done three cycles after the request.
        mem_arr[32'h3C0005] = 8'hA5; ref_arr[32'h3C0005] = 8'hA5;
        wd = 0; wcnt = 0;
        set_req(1, 32'h3C0005, 0, 8'h00);
        tick();
        clr_req();
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            if (cpu_done && lat == 0) lat = i;
            tick();
        end
        check("t1_latency", lat, 3);
        check("t1_dout", 32'(cpu_dout), 32'hA5);

        // PPU and CPU together, then a new PPU request during CPU service.
        done_q.delete();
        set_req(0, 32'h000100, 0, 0); set_req(1, 32'h000200, 0, 0);
        tick();
        clr_req();
        run(4);
        set_req(0, 32'h000101, 0, 0);
        tick();
        clr_req();
        run(15);
        check("t2_count", done_q.size(), 3);
        check("t2_first", q_at(0), 0);
        check("t2_second", q_at(1), 1);
        check("t2_third", q_at(2), 0);

        // Overflow: second CPU request while busy is dropped.
        acks0 = n_acks;
        set_req(1, 32'h000300, 0, 0);
        tick();
        set_req(1, 32'h000301, 0, 0);
        tick();
        clr_req();
        run(8);
        check("t3_ovf", 32'(cpu_ovf), 1);
        check("t3_one_txn", n_acks - acks0, 1);

        // Boot load: only the loader is serviced; CPU goes after ldr_mode falls.
        done_q.delete();
        st_ldr = 1;
        set_req(2, 32'h000010, 1, 8'h4E); set_req(1, 32'h000020, 0, 0);
        tick();
        clr_req();
        run(10);
        check("t4_ldr_only", done_q.size(), 1);
        check("t4_ldr_first", q_at(0), 2);
        check("t4_ldr_write", 32'(mem_rd(32'h10)), 32'h4E);
        st_ldr = 0;
        run(8);
        check("t4_cpu_after", q_at(1), 1);

        // Continuous PPU requests plus one CPU request.
        done_q.delete();
        for (int i = 0; i < 30; i++) begin
            set_req(0, 32'h000400 + i, 0, 0);
            if (i == 2) set_req(1, 32'h000500, 0, 0);
            tick();
            clr_req();
        end
        run(8);
        pos = -1;
        for (int i = 0; i < done_q.size(); i++) if (done_q[i] == 1 && pos < 0) pos = i;
        check("t5_cpu_seen", 32'(pos >= 0), 1);
        check("t5_cpu_within2", 32'(pos <= 2), 1);

        // Reset in WAIT with a late acknowledge arriving in IDLE.
        done_q.delete();
        mem_auto = 0; force_ack = 0; force_rdata = 8'h77;
        set_req(1, 32'h000600, 0, 0);
        tick();
        clr_req();
        tick();
        check("t6_in_wait", 32'(mem_if.mem_req), 1);
        st_reset = 1;
        tick();
        st_reset = 0;
        tick();
        force_ack = 1;
        tick();
        force_ack = 0;
        run(4);
        check("t6_no_done", done_q.size(), 0);
        check("t6_dout", 32'(cpu_dout), 0);
        check("t6_no_req", 32'(mem_if.mem_req), 0);
        mem_auto = 1; wcnt = 0; wd = 0;

        // Randomized traffic with variable memory latency and ldr_mode phases.
        max_wd = 3;
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 120) == 0) st_ldr = ~st_ldr;
            for (int a = 0; a < 3; a++) begin
                st_req[a] = ($urandom % 100) < (a == 0 ? 30 : 20);
                st_addr[a] = $urandom_range(0, 31) | (($urandom % 4 == 0) ? 32'h3C0000 : 0);
                st_we[a] = $urandom % 2;
                st_din[a] = 8'($urandom);
            end
            tick();
        end
        clr_req();
        st_ldr = 0;
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
